// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter sharing one single-port hash memory among NUM_REQ SHA-256 engines.
// Burst ownership with bounded length; read data is steered back to whichever requester issued the read.
module sha_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_clk,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_read_data
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_n;
    logic [IW-1:0]      owner_q, owner_n;
    logic [IW-1:0]      ptr_q, ptr_n;
    logic [IW-1:0]      rd_owner_q;
    logic [BW-1:0]      bcnt_q, bcnt_n;
    logic [NUM_REQ-1:0] gnt_q, gnt_n;
    logic               rd_pend_q;

    logic               access, owner_we, others, at_limit;
    logic [IW-1:0]      owner_inc, win_ptr, win_next;
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First asserted request scanning start, start+1, ... modulo NUM_REQ.
    function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] r, input logic [IW-1:0] start);
        logic [IW-1:0] win;
        logic [IW-1:0] sel;
        int            idx;
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NUM_REQ;
            sel = IW'(idx);
            if (r[sel]) win = sel;
        end
        return win;
    endfunction

    assign access    = |(gnt_q & req);
    assign owner_we  = req_we[owner_q];
    assign others    = |(req & ~onehot(owner_q));
    assign at_limit  = bcnt_q >= BW'(MAX_BURST - 1);
    assign owner_inc = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign win_ptr   = pick(req, ptr_q);
    assign win_next  = pick(req, owner_inc);

    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        bcnt_n  = bcnt_q;
        gnt_n   = gnt_q;
        if (access && bcnt_q != BW'(MAX_BURST)) bcnt_n = bcnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_n = win_ptr;
                    gnt_n   = onehot(win_ptr);
                    bcnt_n  = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (!req[owner_q]) begin
                    ptr_n = owner_inc;
                    if (|req) begin
                        owner_n = win_next;
                        gnt_n   = onehot(win_next);
                        bcnt_n  = '0;
                    end else begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (access && at_limit && others) begin
                    // Burst budget spent while someone waits: hand over next cycle.
                    ptr_n   = owner_inc;
                    owner_n = win_next;
                    gnt_n   = onehot(win_next);
                    bcnt_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            bcnt_q     <= '0;
            gnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
        end else begin
            state_q    <= state_n;
            owner_q    <= owner_n;
            ptr_q      <= ptr_n;
            bcnt_q     <= bcnt_n;
            gnt_q      <= gnt_n;
            rd_pend_q  <= access & ~owner_we;
            rd_owner_q <= owner_q;
        end
    end

    // Read return follows the issuing requester, not the current grant.
    assign rvalid         = rd_pend_q ? onehot(rd_owner_q) : '0;
    assign gnt            = gnt_q;
    assign rdata          = mem_read_data;
    assign mem_clk        = clk;
    assign mem_we         = access & owner_we;
    assign mem_addr       = access ? addr_arr[owner_q] : '0;
    assign mem_write_data = access ? wdata_arr[owner_q] : '0;
endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Bench for sha_mem_arbiter: reactive requester drivers, a spec-level arbitration model feeding
// per-cycle and read-return expectation queues, and an independent monitor that drains them.
module tb_sha_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MB = 4;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [N-1:0]  rvalid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cyc_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, mem_write_data, mem_read_data;
    logic            mem_clk, mem_we;
    logic [AW-1:0]   mem_addr;

    sha_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_clk(mem_clk),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency.
    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ref_mem [0:255];

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (i * 32'h0101_0101);
    endfunction

    initial for (int i = 0; i < 256; i++) ram[i] <= init_word(i);

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_write_data;
        mem_read_data <= ram[mem_addr[7:0]];
    end

    // Scoreboard state.
    cyc_t            cyc_q[$];
    logic [DW+1:0]   exp_q[$];
    int              n_tests = 0;
    int              n_fail = 0;

    // Requester driver state.
    bit              act[N], go[N];
    int              rem[N], done[N], mode[N], base[N], rpt[N];
    int              go_len[N], go_base[N], go_mode[N];
    logic [DW-1:0]   fix_data[N];
    int              rst_cycles = 0;

    // Reference model state.
    int              m_owner, m_ptr, m_cnt, m_o;
    bit              m_acc;
    logic [N-1:0]    m_rv;
    logic [AW-1:0]   m_a;
    cyc_t            m_rec;

    cyc_t            mon_e;
    logic [DW+1:0]   mon_r;

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int who);
        return N'(1) << who;
    endfunction

    function automatic int first_req(input logic [N-1:0] r, input int start);
        logic [1:0] idx;
        for (int k = 0; k < N; k++) begin
            idx = 2'((start + k) % N);
            if (r[idx]) return int'(idx);
        end
        return -1;
    endfunction

    // Driver + model: drive this cycle's inputs at negedge, then predict this cycle's outputs and next grant.
    initial begin
        reset = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            act[i] = 0; go[i] = 0; rem[i] = 0; done[i] = 0; mode[i] = 0; base[i] = 0; rpt[i] = 0;
            go_len[i] = 0; go_base[i] = 0; go_mode[i] = 0; fix_data[i] = '0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_rv = '0;
        repeat (3) @(posedge clk);
        forever begin
            @(negedge clk);
            reset = (rst_cycles > 0);
            if (rst_cycles > 0) rst_cycles--;
            for (int i = 0; i < N; i++) begin
                if (act[i]) begin
                    if (rem[i] == 0) begin
                        req[i] = 1'b0; req_we[i] = 1'b0; act[i] = 0;
                        if (rpt[i] > 0) begin rpt[i]--; go[i] = 1; end
                    end else if (gnt[i]) begin
                        req_addr[i*AW +: AW] = AW'(base[i] + done[i]);
                        case (mode[i])
                            0:       req_we[i] = 1'b0;
                            2:       req_we[i] = 1'($urandom_range(0, 1));
                            default: req_we[i] = 1'b1;
                        endcase
                        req_wdata[i*DW +: DW] = (mode[i] == 3) ? fix_data[i] : DW'($urandom);
                        done[i]++; rem[i]--;
                    end
                end else if (go[i]) begin
                    go[i] = 0; act[i] = 1; rem[i] = go_len[i]; done[i] = 0;
                    base[i] = go_base[i]; mode[i] = go_mode[i];
                    req[i] = 1'b1; req_we[i] = 1'b0;
                end
            end
            m_o   = m_owner;
            m_acc = (m_o >= 0) && req[m_o];
            m_rec.gnt    = (m_o >= 0) ? oh(m_o) : '0;
            m_rec.rvalid = m_rv;
            m_rec.we     = m_acc ? req_we[m_o] : 1'b0;
            m_rec.addr   = m_acc ? req_addr[m_o*AW +: AW] : '0;
            m_rec.wdata  = m_acc ? req_wdata[m_o*DW +: DW] : '0;
            cyc_q.push_back(m_rec);
            m_rv = '0;
            if (m_acc) begin
                m_a = req_addr[m_o*AW +: AW];
                if (req_we[m_o]) ref_mem[m_a[7:0]] = req_wdata[m_o*DW +: DW];
                else if (!reset) begin
                    m_rv = oh(m_o);
                    exp_q.push_back({2'(m_o), ref_mem[m_a[7:0]]});
                end
            end
            if (reset) begin
                m_owner = -1; m_ptr = 0; m_cnt = 0;
            end else if (m_o < 0) begin
                m_owner = first_req(req, m_ptr); m_cnt = 0;
            end else begin
                if (m_acc) m_cnt++;
                if (!req[m_o]) begin
                    m_ptr = (m_o + 1) % N;
                    m_owner = first_req(req, m_ptr); m_cnt = 0;
                end else if (m_acc && m_cnt >= MB && (req & ~oh(m_o)) != '0) begin
                    m_owner = first_req(req, (m_o + 1) % N); m_cnt = 0;
                end
            end
        end
    end

    // Monitor: drains expectations whenever the DUT presents outputs.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() > 0) begin
                mon_e = cyc_q.pop_front();
                chk("gnt", gnt, mon_e.gnt);
                chk("rvalid", rvalid, mon_e.rvalid);
                chk("mem_we", mem_we, mon_e.we);
                chk("mem_addr", mem_addr, mon_e.addr);
                chk("mem_write_data", mem_write_data, mon_e.wdata);
                chk("mem_clk", mem_clk, clk);
            end
            if (rvalid != '0) begin
                if (exp_q.size() == 0) chk("rvalid_unexpected", rvalid, '0);
                else begin
                    mon_r = exp_q.pop_front();
                    chk("rvalid_who", rvalid, oh(int'(mon_r[DW+1:DW])));
                    chk("rdata", rdata, mon_r[DW-1:0]);
                end
            end
        end
    end

    task automatic start(input int i, input int len, input int b, input int md, input int rp);
        go_len[i] = len; go_base[i] = b; go_mode[i] = md; rpt[i] = rp; go[i] = 1;
    endtask

    task automatic wait_idle(input int max_cycles);
        bit idle;
        idle = 0;
        for (int c = 0; c < max_cycles && !idle; c++) begin
            @(posedge clk);
            idle = 1;
            for (int i = 0; i < N; i++) if (act[i] || go[i] || rpt[i] != 0) idle = 0;
        end
        chk("wait_idle_timeout", idle, 1'b1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        start(2, 4, 'h10, 0, 0);
        wait_idle(60);
        start(0, 3, 'h40, 0, 3);
        start(1, 3, 'h50, 0, 3);
        wait_idle(120);
        start(3, 10, 'h60, 0, 0);
        repeat (2) @(posedge clk);
        start(1, 2, 'h70, 0, 0);
        wait_idle(120);
        start(0, 3, 'h1E, 0, 0);
        @(posedge clk);
        start(1, 2, 'h80, 0, 0);
        wait_idle(60);
        fix_data[1] = 32'hDEAD_BEEF;
        start(1, 1, 'h30, 3, 0);
        wait_idle(60);
        chk("ram_0x30", ram[8'h30], 32'hDEAD_BEEF);
        start(1, 1, 'h30, 0, 0);
        wait_idle(60);
        start(2, 12, 'h90, 0, 0);
        repeat (4) @(posedge clk);
        rst_cycles = 1;
        start(0, 3, 'hA0, 0, 0);
        wait_idle(120);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            if ($urandom_range(0, 99) == 0) rst_cycles = 1;
            for (int i = 0; i < N; i++)
                if (!act[i] && !go[i] && rpt[i] == 0 && $urandom_range(0, 3) == 0)
                    start(i, $urandom_range(1, 7), $urandom_range(0, 240), $urandom_range(0, 2), 0);
        end
        wait_idle(400);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
